// File: rtl/icache_bridge_pkg.sv
// Shared definitions for the instruction-cache bridge: FSM encoding and the
// backend address-space convention (instr halfword pairs vs. data halfwords).
package icache_bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOOKUP  = 3'd1,
        ST_FILL_LO = 3'd2,
        ST_FILL_HI = 3'd3,
        ST_PASS    = 3'd4,
        ST_RESP    = 3'd5
    } state_t;

    // Instruction words occupy two halfwords {addr,hw}; data halfwords sit at {0,addr}.
    localparam logic DATA_SPACE_MSB = 1'b0;
    localparam logic HW_LO          = 1'b0;
    localparam logic HW_HI          = 1'b1;

    function automatic logic is_mem_state(input state_t s);
        return (s == ST_FILL_LO) || (s == ST_FILL_HI) || (s == ST_PASS);
    endfunction

endpackage

// File: rtl/icache_store.sv
// Data + tag array for the direct-mapped instruction cache.
// One synchronous write port, asynchronous read; valid bits live in the parent.
module icache_store #(
    parameter int INDEX_BITS = 6,
    parameter int TAG_W      = 14
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [INDEX_BITS-1:0] i_widx,
    input  logic [TAG_W-1:0]      i_wtag,
    input  logic [31:0]           i_wdata,
    input  logic [INDEX_BITS-1:0] i_ridx,
    output logic [TAG_W-1:0]      o_rtag,
    output logic [31:0]           o_rdata
);

    localparam int LINES = 1 << INDEX_BITS;

    logic [TAG_W-1:0] r_tag  [LINES];
    logic [31:0]      r_data [LINES];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_tag[i_widx]  <= i_wtag;
            r_data[i_widx] <= i_wdata;
        end
    end

    assign o_rtag  = r_tag[i_ridx];
    assign o_rdata = r_data[i_ridx];

endmodule

// File: rtl/icache_bridge.sv
// Direct-mapped instruction cache in front of the 16-bit SDRAM controller.
// Instruction reads hit or fill a 2-halfword line; everything else passes through.
module icache_bridge
    import icache_bridge_pkg::*;
#(
    parameter int ADDR_W     = 20,
    parameter int INDEX_BITS = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_read,
    input  logic              cpu_write,
    input  logic              cpu_instr,
    input  logic [15:0]       cpu_wdata,
    output logic [15:0]       cpu_rdata,
    output logic [31:0]       cpu_ins,
    output logic              cpu_busy,
    output logic              cpu_cack,
    output logic              cpu_ready,
    input  logic              flush,
    output logic              mem_req,
    output logic              mem_we,
    output logic              mem_isp,
    output logic [ADDR_W:0]   mem_addr,
    output logic [15:0]       mem_wdata,
    input  logic [15:0]       mem_rdata,
    input  logic              mem_ack
);

    localparam int TAG_W = ADDR_W - INDEX_BITS;
    localparam int LINES = 1 << INDEX_BITS;

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_instr;
    logic                r_write;
    logic [15:0]         r_wdata;
    logic [15:0]         r_lo;
    logic                r_stale;
    logic                r_req;
    logic [31:0]         r_ins;
    logic [15:0]         r_rdata;
    logic [LINES-1:0]    r_valid;

    logic                w_req_next;
    logic                w_hw;
    logic                w_ack;
    logic                w_ifetch;
    logic                w_tag_eq;
    logic                w_hit;
    logic                w_st_we;
    logic                w_accept;
    logic [INDEX_BITS-1:0] w_idx;
    logic [TAG_W-1:0]    w_tag;
    logic [TAG_W-1:0]    w_st_tag;
    logic [31:0]         w_st_data;

    assign w_idx    = r_addr[INDEX_BITS-1:0];
    assign w_tag    = r_addr[ADDR_W-1:INDEX_BITS];
    assign w_accept = (r_state == ST_IDLE) && (cpu_read || cpu_write);
    // An ack only counts while we are actually requesting; strays (e.g. after reset) are dropped.
    assign w_ack    = mem_ack && r_req;
    // Write wins when read and write are both raised, so only a pure read fetches.
    assign w_ifetch = r_instr && !r_write;
    assign w_tag_eq = (w_st_tag == w_tag);
    assign w_hit    = r_valid[w_idx] && w_tag_eq;
    assign w_st_we  = (r_state == ST_FILL_HI) && w_ack;

    icache_store #(
        .INDEX_BITS (INDEX_BITS),
        .TAG_W      (TAG_W)
    ) u_store (
        .clk     (clk),
        .i_we    (w_st_we),
        .i_widx  (w_idx),
        .i_wtag  (w_tag),
        .i_wdata ({mem_rdata, r_lo}),
        .i_ridx  (w_idx),
        .o_rtag  (w_st_tag),
        .o_rdata (w_st_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:    if (cpu_read || cpu_write) w_next = ST_LOOKUP;
            ST_LOOKUP: begin
                if (!w_ifetch)  w_next = ST_PASS;
                else if (w_hit) w_next = ST_RESP;
                else            w_next = ST_FILL_LO;
            end
            ST_FILL_LO: if (w_ack) w_next = ST_FILL_HI;
            ST_FILL_HI: if (w_ack) w_next = ST_RESP;
            ST_PASS:    if (w_ack) w_next = ST_RESP;
            ST_RESP:    w_next = ST_IDLE;
            default:    w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        cpu_cack   = 1'b0;
        cpu_busy   = 1'b0;
        cpu_ready  = 1'b0;
        mem_we     = 1'b0;
        mem_isp    = 1'b0;
        w_hw       = HW_LO;
        case (r_state)
            ST_IDLE:    cpu_cack = cpu_read || cpu_write;
            ST_LOOKUP:  cpu_busy = 1'b1;
            ST_FILL_LO: begin
                cpu_busy = 1'b1;
                mem_isp  = 1'b1;
            end
            ST_FILL_HI: begin
                cpu_busy = 1'b1;
                mem_isp  = 1'b1;
                w_hw     = HW_HI;
            end
            ST_PASS: begin
                cpu_busy = 1'b1;
                mem_we   = r_write;
                mem_isp  = r_instr;
            end
            ST_RESP:    cpu_ready = 1'b1;
            default:    cpu_busy = 1'b0;
        endcase
        // Request drops for one cycle after every ack, including between the two fill halves.
        w_req_next = is_mem_state(w_next) && !w_ack;
    end

    assign mem_req   = r_req;
    assign mem_addr  = r_instr ? {r_addr, w_hw} : {DATA_SPACE_MSB, r_addr};
    assign mem_wdata = r_wdata;
    assign cpu_ins   = r_ins;
    assign cpu_rdata = r_rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr  <= '0;
            r_instr <= 1'b0;
            r_write <= 1'b0;
            r_wdata <= '0;
            r_lo    <= '0;
            r_stale <= 1'b0;
            r_req   <= 1'b0;
            r_ins   <= '0;
            r_rdata <= '0;
        end else begin
            r_req <= w_req_next;
            if (w_accept) begin
                r_addr  <= cpu_addr;
                r_instr <= cpu_instr;
                r_write <= cpu_write;
                r_wdata <= cpu_wdata;
                r_stale <= 1'b0;
            end
            // A flush racing a fill means the fetched line may predate the flush.
            if (flush && ((r_state == ST_FILL_LO) || (r_state == ST_FILL_HI))) begin
                r_stale <= 1'b1;
            end
            if ((r_state == ST_FILL_LO) && w_ack) begin
                r_lo <= mem_rdata;
            end
            if ((r_state == ST_LOOKUP) && w_ifetch && w_hit) begin
                r_ins <= w_st_data;
            end
            if (w_st_we) begin
                r_ins <= {mem_rdata, r_lo};
            end
            if ((r_state == ST_PASS) && w_ack && !r_write) begin
                r_rdata <= mem_rdata;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
        end else if (flush) begin
            r_valid <= '0;
        end else begin
            if (w_st_we && !r_stale) begin
                r_valid[w_idx] <= 1'b1;
            end
            // Self-modifying code: an instruction-space write drops the cached copy.
            if ((r_state == ST_PASS) && w_ack && r_write && r_instr && w_tag_eq) begin
                r_valid[w_idx] <= 1'b0;
            end
        end
    end

endmodule
